uart_cmd_ctrl: RTL

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

---
 rtl/uart_cmd_pkg.sv | 21 ++
 rtl/uart_cmd_timeout.sv | 34 +++
 rtl/uart_cmd_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command frame controller.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_CHK  = 2'd3
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         FRAME_LEN         = 4;

    // XOR checksum carried in the last byte of a frame
    function automatic logic [7:0] frame_chk(input logic [7:0] sync_byte,
                                             input logic [7:0] addr,
                                             input logic [7:0] data);
        return sync_byte ^ addr ^ data;
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout counter; expired pulses on the cycle the limit is reached
// while enabled and not being cleared.
module uart_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] ONE   = CW'(1);

    logic [CW-1:0] count_r;

    // Count idle cycles of an open frame, holding at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (enable && (count_r != LIMIT)) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = enable && !clear && (count_r == LIMIT);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses SYNC/ADDR/DATA/CHK byte frames from a UART receiver and writes a
// small register bank; bad or stalled frames are counted as errors.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         NUM_REGS       = 4,
    parameter int         TIMEOUT_CYCLES = 200000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [NUM_REGS*8-1:0] reg_bank,
    output logic                  wr_strobe,
    output logic [7:0]            wr_addr,
    output logic                  frame_err,
    output logic [7:0]            err_count,
    output logic                  busy
);

    state_t     state_r;
    logic [7:0] addr_r;
    logic [7:0] data_r;
    logic       expired_s;

    uart_cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (rx_valid || (state_r == ST_IDLE)),
        .enable (state_r != ST_IDLE),
        .expired(expired_s)
    );

    // Frame FSM with registered write/error outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            addr_r    <= 8'h00;
            data_r    <= 8'h00;
            reg_bank  <= {(NUM_REGS*8){1'b0}};
            wr_strobe <= 1'b0;
            wr_addr   <= 8'h00;
            frame_err <= 1'b0;
            err_count <= 8'h00;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            if (rx_valid) begin
                case (state_r)
                    ST_IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            state_r <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        addr_r  <= rx_data;
                        state_r <= ST_DATA;
                    end
                    ST_DATA: begin
                        data_r  <= rx_data;
                        state_r <= ST_CHK;
                    end
                    ST_CHK: begin
                        state_r <= ST_IDLE;
                        // Bad checksum and bad address collapse into one error
                        if ((rx_data == frame_chk(SYNC_BYTE, addr_r, data_r)) &&
                            (int'(addr_r) < NUM_REGS)) begin
                            reg_bank[int'(addr_r)*8 +: 8] <= data_r;
                            wr_addr   <= addr_r;
                            wr_strobe <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            if (err_count != 8'hFF) begin
                                err_count <= err_count + 8'h01;
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end else if (expired_s) begin
                state_r   <= ST_IDLE;
                frame_err <= 1'b1;
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'h01;
                end
            end
        end
    end

    assign busy = (state_r != ST_IDLE);

endmodule
